hdlc_tx_channel: RTL and testbench
==================================

Name: hdlc_tx_channel

Overview:
Serial transmit path of the HDLC controller, the counterpart of the Rx channel. It takes a frame from the Tx buffer one byte at a time and drives it onto Tx at one bit per Clk. It adds an opening flag, zero insertion, an optional 16-bit FCS and a closing flag, and it can abort a frame. Its output loops back to the Rx channel for verification.

Parameters:
MAX_FRAME_SIZE, 126, maximum number of payload bytes accepted per frame (excludes FCS).

Ports:
Clk  input  1  system clock.
Rst  input  1  synchronous reset, active-high.
Tx_Start  input  1  single-cycle request to send a frame.
Tx_FrameSize  input  8  payload byte count, sampled with Tx_Start.
Tx_FCSen  input  1  append FCS; sampled with Tx_Start.
Tx_AbortFrame  input  1  abort the frame in progress.
Tx_Data  input  8  buffer byte, valid the cycle after a Tx_RdBuff pulse.
Tx_RdBuff  output  1  single-cycle read strobe to the Tx buffer.
Tx  output  1  serial line, bit 0 of each byte first.
TxEN  output  1  high while a flag, frame or abort pattern is on Tx.
Tx_Busy  output  1  high whenever the state is not IDLE.
Tx_Done  output  1  single-cycle pulse when a frame has been sent normally.
Tx_AbortedTrans  output  1  single-cycle pulse when an abort pattern has completed.

Behaviour:
- Reset values: Tx=1, TxEN=0, Tx_RdBuff=0, Tx_Busy=0, Tx_Done=0, Tx_AbortedTrans=0. State goes to IDLE and all counters and the CRC clear.
- Reset mid-frame: the outputs return to reset values at that edge. No Done or Aborted pulse is issued.
- Start rules:
  - Tx_Start in IDLE with 1 <= Tx_FrameSize <= MAX_FRAME_SIZE is accepted.
  - Tx_Start is ignored when busy, when Tx_FrameSize = 0, or when Tx_FrameSize > MAX_FRAME_SIZE. No outputs change.
- States: IDLE -> START_FLAG -> DATA -> FCS (only if Tx_FCSen) -> END_FLAG -> IDLE. ABORT is reachable from START_FLAG, DATA and FCS.
- Latency: the first flag bit appears on Tx, with TxEN=1, in the cycle after Tx_Start is accepted.
- Flag: 0x7E sent as bits 0,1,1,1,1,1,1,0. No zero insertion inside flags.
- Byte fetch:
  - Tx_RdBuff pulses in the first cycle of START_FLAG.
  - It pulses again in the cycle the first bit of each payload byte is driven, while bytes remain.
  - Exactly Tx_FrameSize pulses are issued per non-aborted frame.
  - Tx_Data is captured into a holding register the cycle after each pulse.
- Zero insertion:
  - A ones counter covers DATA and FCS bits and runs continuously across byte boundaries. It clears on every flag bit.
  - After the fifth consecutive 1, a 0 is inserted in the next cycle and the counter clears.
  - An inserted 0 does not consume a payload bit and is not fed to the CRC.
- FCS:
  - CRC-16, polynomial x^16+x^15+x^2+1, initial value 0x0000, no final inversion.
  - Computed over the payload bits in transmit order.
  - Sent as 16 bits, low byte first, bit 0 first, with zero insertion applied.
- Done: after the last bit of the closing flag, at the next edge the state returns to IDLE, TxEN=0, Tx=1, and Tx_Done pulses for 1 cycle.
- Abort:
  - Tx_AbortFrame in START_FLAG, DATA or FCS completes the current bit, then sends 0 followed by seven 1s (8 cycles, no insertion).
  - No further Tx_RdBuff pulses are issued.
  - Then IDLE, TxEN=0, and Tx_AbortedTrans pulses for 1 cycle. Tx_Done is not asserted.
  - Tx_AbortFrame in IDLE, END_FLAG or ABORT is ignored.
- Simultaneous events: Rst has priority over everything. Tx_AbortFrame takes effect in the cycle Tx_Start is accepted only from the next cycle on, so the first flag bit is still sent.
- Idle line: Tx=1 continuously.

Test Plan:
- Size 1, Tx_Data=0x00, FCSen=0 -> Tx = 01111110 00000000 01111110. TxEN high for exactly 24 cycles. One Tx_RdBuff pulse. Tx_Done one cycle after the last flag bit.
- Size 1, Tx_Data=0xFF, FCSen=0 -> data field 11111 0 111 (9 cycles). Closing flag follows immediately. TxEN high for 25 cycles.
- Size 2, bytes 0xF0, 0x0F, FCSen=0 -> data field 0000 11111 0 111 0000 (17 cycles). The ones run carries across the boundary. Two Tx_RdBuff pulses.
- Size 4, bytes 0x01 0x02 0x03 0x04, FCSen=1, Tx looped to Rx channel -> Rx_FrameSize=4, Rx data matches, Rx_FCSerr=0. The transmitted FCS bits equal the bench CRC model.
- Size 10, Tx_AbortFrame asserted during byte 3 -> after the current bit, Tx = 0 then 1111111. TxEN drops after 8 cycles. Tx_AbortedTrans pulses, Tx_Done stays 0, and no more than 3 or 4 Tx_RdBuff pulses occur in total.
- Rejects and reset -> Tx_Start with size 0, with size 127, and while busy produce no change on any output. Rst mid-DATA gives Tx=1, TxEN=0, Tx_Busy=0 at the next edge, with no Done or Aborted pulse.

Source files
------------

// File: rtl/hdlc_tx_channel.sv
// HDLC transmit channel: serialises a buffered frame onto Tx as
// opening flag, zero-inserted payload, optional CRC-16 FCS, closing flag.
// An abort replaces the rest of the frame with 0 followed by seven 1s.
module hdlc_tx_channel #(
  parameter int MAX_FRAME_SIZE = 126
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Start,
  input  logic [7:0] Tx_FrameSize,
  input  logic       Tx_FCSen,
  input  logic       Tx_AbortFrame,
  input  logic [7:0] Tx_Data,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       TxEN,
  output logic       Tx_Busy,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans
);

  typedef enum logic [2:0] {
    IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT
  } state_t;

  localparam logic [7:0]  FLAG     = 8'h7E;
  localparam logic [7:0]  MAX_SIZE = 8'(MAX_FRAME_SIZE);
  localparam logic [15:0] CRC_POLY = 16'h8005;

  state_t      state, stateNext;
  logic [3:0]  bitCnt, bitCntNext;
  logic [7:0]  byteCnt, byteCntNext;
  logic [7:0]  fetchCnt, fetchCntNext;
  logic [2:0]  onesCnt, onesCntNext;
  logic [15:0] crc, crcNext;
  logic        fieldDone, fieldDoneNext;
  logic [7:0]  frameSize;
  logic        fcsEn;
  logic [7:0]  holdReg, curByte;
  logic        rdDly;
  logic        doneReg, abortedReg;
  logic        doneNext, abortedNext;
  logic        loadByte;
  logic        startOk;
  logic        stuffNow;
  logic        curBit, fcsBit;
  logic        txBit, txEnComb, rdComb;

  // One serial step of CRC-16 (x^16+x^15+x^2+1), MSB-side feedback.
  function automatic logic [15:0] crcStep(input logic [15:0] c, input logic d);
    logic fb;
    fb = c[15] ^ d;
    return {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  assign startOk  = Tx_Start && (Tx_FrameSize != 8'd0) && (Tx_FrameSize <= MAX_SIZE);
  assign stuffNow = (onesCnt == 3'd5);
  assign curBit   = curByte[bitCnt[2:0]];
  assign fcsBit   = crc[bitCnt];

  // Next-state, bit selection and strobes for the serialiser.
  always_comb begin
    stateNext     = state;
    bitCntNext    = bitCnt;
    byteCntNext   = byteCnt;
    fetchCntNext  = fetchCnt;
    onesCntNext   = onesCnt;
    crcNext       = crc;
    fieldDoneNext = fieldDone;
    loadByte      = 1'b0;
    doneNext      = 1'b0;
    abortedNext   = 1'b0;
    txBit         = 1'b1;
    txEnComb      = 1'b1;
    rdComb        = 1'b0;
    case (state)
      IDLE: begin
        txEnComb = 1'b0;
        if (startOk) begin
          stateNext     = START_FLAG;
          bitCntNext    = 4'd0;
          byteCntNext   = 8'd0;
          fetchCntNext  = 8'd0;
          onesCntNext   = 3'd0;
          crcNext       = 16'h0000;
          fieldDoneNext = 1'b0;
        end
      end
      START_FLAG: begin
        txBit       = FLAG[bitCnt[2:0]];
        onesCntNext = 3'd0;
        if (bitCnt == 4'd0) begin
          rdComb       = 1'b1;
          fetchCntNext = fetchCnt + 8'd1;
        end
        if (Tx_AbortFrame) begin
          stateNext  = ABORT;
          bitCntNext = 4'd0;
        end else if (bitCnt == 4'd7) begin
          stateNext  = DATA;
          bitCntNext = 4'd0;
          loadByte   = 1'b1;
        end else begin
          bitCntNext = bitCnt + 4'd1;
        end
      end
      DATA: begin
        if (stuffNow) begin
          // Inserted zero: no payload bit consumed, CRC untouched.
          txBit       = 1'b0;
          onesCntNext = 3'd0;
          if (fieldDone) begin
            fieldDoneNext = 1'b0;
            bitCntNext    = 4'd0;
            stateNext     = fcsEn ? FCS : END_FLAG;
          end
        end else begin
          txBit       = curBit;
          onesCntNext = curBit ? onesCnt + 3'd1 : 3'd0;
          crcNext     = crcStep(crc, curBit);
          if (bitCnt == 4'd0 && fetchCnt < frameSize) begin
            rdComb       = 1'b1;
            fetchCntNext = fetchCnt + 8'd1;
          end
          if (bitCnt == 4'd7) begin
            bitCntNext = 4'd0;
            if (byteCnt == frameSize - 8'd1) begin
              // A fifth 1 on the last bit still needs its zero before the next field.
              if (curBit && onesCnt == 3'd4) fieldDoneNext = 1'b1;
              else stateNext = fcsEn ? FCS : END_FLAG;
            end else begin
              byteCntNext = byteCnt + 8'd1;
              loadByte    = 1'b1;
            end
          end else begin
            bitCntNext = bitCnt + 4'd1;
          end
        end
        if (Tx_AbortFrame) begin
          stateNext     = ABORT;
          bitCntNext    = 4'd0;
          fieldDoneNext = 1'b0;
        end
      end
      FCS: begin
        if (stuffNow) begin
          txBit       = 1'b0;
          onesCntNext = 3'd0;
          if (fieldDone) begin
            fieldDoneNext = 1'b0;
            bitCntNext    = 4'd0;
            stateNext     = END_FLAG;
          end
        end else begin
          txBit       = fcsBit;
          onesCntNext = fcsBit ? onesCnt + 3'd1 : 3'd0;
          if (bitCnt == 4'd15) begin
            bitCntNext = 4'd0;
            if (fcsBit && onesCnt == 3'd4) fieldDoneNext = 1'b1;
            else stateNext = END_FLAG;
          end else begin
            bitCntNext = bitCnt + 4'd1;
          end
        end
        if (Tx_AbortFrame) begin
          stateNext     = ABORT;
          bitCntNext    = 4'd0;
          fieldDoneNext = 1'b0;
        end
      end
      END_FLAG: begin
        txBit       = FLAG[bitCnt[2:0]];
        onesCntNext = 3'd0;
        if (bitCnt == 4'd7) begin
          stateNext  = IDLE;
          bitCntNext = 4'd0;
          doneNext   = 1'b1;
        end else begin
          bitCntNext = bitCnt + 4'd1;
        end
      end
      ABORT: begin
        txBit = (bitCnt != 4'd0);
        if (bitCnt == 4'd7) begin
          stateNext   = IDLE;
          bitCntNext  = 4'd0;
          abortedNext = 1'b1;
        end else begin
          bitCntNext = bitCnt + 4'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Control state, counters, CRC and completion pulses.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      bitCnt     <= 4'd0;
      byteCnt    <= 8'd0;
      fetchCnt   <= 8'd0;
      onesCnt    <= 3'd0;
      crc        <= 16'h0000;
      fieldDone  <= 1'b0;
      frameSize  <= 8'd0;
      fcsEn      <= 1'b0;
      rdDly      <= 1'b0;
      doneReg    <= 1'b0;
      abortedReg <= 1'b0;
    end else begin
      state      <= stateNext;
      bitCnt     <= bitCntNext;
      byteCnt    <= byteCntNext;
      fetchCnt   <= fetchCntNext;
      onesCnt    <= onesCntNext;
      crc        <= crcNext;
      fieldDone  <= fieldDoneNext;
      rdDly      <= rdComb;
      doneReg    <= doneNext;
      abortedReg <= abortedNext;
      if (state == IDLE && startOk) begin
        frameSize <= Tx_FrameSize;
        fcsEn     <= Tx_FCSen;
      end
    end
  end

  // Byte path: buffer data lands in holdReg, then moves to the shifter per byte.
  always_ff @(posedge Clk) begin
    if (rdDly) holdReg <= Tx_Data;
    if (loadByte) curByte <= holdReg;
  end

  assign Tx              = txBit;
  assign TxEN            = txEnComb;
  assign Tx_RdBuff       = rdComb;
  assign Tx_Busy         = (state != IDLE);
  assign Tx_Done         = doneReg;
  assign Tx_AbortedTrans = abortedReg;

endmodule

// File: tb/tb_hdlc_tx_channel.sv
// Bench for hdlc_tx_channel: table of frames with hand-derived line bit
// streams, plus directed abort, reject and mid-frame reset sequences.
module tb_hdlc_tx_channel;

  logic       Clk = 1'b0;
  logic       Rst, Tx_Start, Tx_FCSen, Tx_AbortFrame;
  logic [7:0] Tx_FrameSize, Tx_Data;
  logic       Tx_RdBuff, Tx, TxEN, Tx_Busy, Tx_Done, Tx_AbortedTrans;

  hdlc_tx_channel #(.MAX_FRAME_SIZE(126)) dut (
    .Clk(Clk), .Rst(Rst), .Tx_Start(Tx_Start), .Tx_FrameSize(Tx_FrameSize),
    .Tx_FCSen(Tx_FCSen), .Tx_AbortFrame(Tx_AbortFrame), .Tx_Data(Tx_Data),
    .Tx_RdBuff(Tx_RdBuff), .Tx(Tx), .TxEN(TxEN), .Tx_Busy(Tx_Busy),
    .Tx_Done(Tx_Done), .Tx_AbortedTrans(Tx_AbortedTrans)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int              size;
    logic            fcsEn;
    logic [3:0][7:0] bytes;
    logic [63:0]     field;    // data (+FCS) field on the line, index = transmit order
    int              fieldLen;
    int              expRd;
  } vec_t;

  vec_t vecs[5];
  int nVec = 0;
  int nFail = 0;

  logic [127:0] got;
  int   nGot, rdCnt, doneCnt, abCnt;
  logic timedOut;
  logic [7:0] bufMem [0:15];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] bitsOf(input string s);
    logic [63:0] v;
    int n;
    byte c;
    v = '0;
    n = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == "0" || c == "1") begin
        v[n] = (c == "1");
        n++;
      end
    end
    return v;
  endfunction

  function automatic logic [127:0] wrapFlags(input logic [63:0] f, input int len);
    logic [127:0] e;
    logic [7:0] fl;
    fl = 8'h7E;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      e[i] = fl[i];
      e[8 + len + i] = fl[i];
    end
    for (int i = 0; i < len; i++) e[8 + i] = f[i];
    return e;
  endfunction

  function automatic logic [15:0] crcModel(input logic [3:0][7:0] b, input int n);
    logic [15:0] c;
    logic fb;
    c = 16'h0000;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++) begin
        fb = c[15] ^ b[i][k];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    return c;
  endfunction

  // Remove inserted zeros from the captured field and return the last 16 bits.
  function automatic logic [15:0] fcsFromLine(input logic [127:0] line, input int len);
    logic [127:0] pay;
    logic [15:0] f;
    int ones, n;
    pay = '0;
    n = 0;
    ones = 0;
    for (int i = 0; i < len; i++) begin
      if (ones == 5) ones = 0;
      else begin
        pay[n] = line[8 + i];
        n++;
        ones = line[8 + i] ? ones + 1 : 0;
      end
    end
    f = '0;
    if (n >= 16)
      for (int k = 0; k < 16; k++) f[k] = pay[n - 16 + k];
    return f;
  endfunction

  task automatic setVec(input int i, input int size, input logic fcs, input logic [31:0] b,
                        input string f, input int len, input int rd);
    vecs[i].size     = size;
    vecs[i].fcsEn    = fcs;
    vecs[i].bytes    = b;
    vecs[i].field    = bitsOf(f);
    vecs[i].fieldLen = len;
    vecs[i].expRd    = rd;
  endtask

  // Start a frame and run it to IDLE, acting as the Tx buffer and capturing the line.
  task automatic runFrame(input int size, input logic fcs, input int abortCyc, input int extraStartCyc);
    int idx;
    logic pend, fin;
    idx = 0; pend = 0; fin = 0;
    got = '0; nGot = 0; rdCnt = 0; doneCnt = 0; abCnt = 0; timedOut = 1'b1;
    @(posedge Clk); #1;
    Tx_Start = 1'b1; Tx_FrameSize = 8'(size); Tx_FCSen = fcs;
    @(posedge Clk); #1;
    Tx_Start = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (pend) begin
        if (idx < 16) Tx_Data = bufMem[idx];
        idx++;
        pend = 0;
      end
      Tx_AbortFrame = (cyc == abortCyc);
      Tx_Start = (cyc == extraStartCyc);
      if (cyc == extraStartCyc) Tx_FrameSize = 8'd1;
      @(negedge Clk);
      if (cyc == 0) check("first flag bit TxEN", TxEN, 1'b1);
      if (TxEN) begin
        if (nGot < 128) got[nGot] = Tx;
        nGot++;
      end
      if (Tx_RdBuff) begin rdCnt++; pend = 1; end
      if (Tx_Done) doneCnt++;
      if (Tx_AbortedTrans) abCnt++;
      if (!Tx_Busy) begin fin = 1; timedOut = 1'b0; end
      @(posedge Clk); #1;
    end
    Tx_Start = 1'b0;
    Tx_AbortFrame = 1'b0;
  endtask

  // Apply an optional one-cycle stimulus in IDLE and require quiet idle outputs.
  task automatic probeIdle(input string name, input logic st, input logic [7:0] sz, input logic ab);
    for (int c = 0; c < 4; c++) begin
      @(posedge Clk); #1;
      Tx_Start = (c == 0) && st;
      Tx_FrameSize = sz;
      Tx_AbortFrame = (c == 0) && ab;
      @(negedge Clk);
      check(name, {Tx, TxEN, Tx_Busy, Tx_RdBuff, Tx_Done, Tx_AbortedTrans}, 6'b100000);
    end
    @(posedge Clk); #1;
    Tx_Start = 1'b0;
    Tx_AbortFrame = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] expLine;
    logic [7:0] ab;
    Rst = 1'b1; Tx_Start = 1'b0; Tx_FrameSize = 8'd0; Tx_FCSen = 1'b0;
    Tx_AbortFrame = 1'b0; Tx_Data = 8'd0;

    setVec(0, 1, 1'b0, 32'h00000000, "00000000", 8, 1);
    setVec(1, 1, 1'b0, 32'h000000FF, "11111_0_111", 9, 1);
    setVec(2, 2, 1'b0, 32'h00000FF0, "0000_11111_0_111_0000", 17, 2);
    setVec(3, 4, 1'b1, 32'h04030201,
           "10000000_01000000_11000000_00100000_0000_11111_0_0100001", 49, 4);
    setVec(4, 1, 1'b0, 32'h000000F8, "000_11111_0", 9, 1);

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset Tx", Tx, 1'b1);
    check("reset TxEN", TxEN, 1'b0);
    check("reset Tx_RdBuff", Tx_RdBuff, 1'b0);
    check("reset Tx_Busy", Tx_Busy, 1'b0);
    check("reset Tx_Done", Tx_Done, 1'b0);
    check("reset Tx_AbortedTrans", Tx_AbortedTrans, 1'b0);
    @(posedge Clk); #1;
    Rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < 4; b++) bufMem[b] = vecs[i].bytes[b];
      runFrame(vecs[i].size, vecs[i].fcsEn, -1, -1);
      check($sformatf("v%0d finished", i), timedOut, 1'b0);
      check($sformatf("v%0d line bits", i), got, wrapFlags(vecs[i].field, vecs[i].fieldLen));
      check($sformatf("v%0d TxEN cycles", i), nGot, vecs[i].fieldLen + 16);
      check($sformatf("v%0d Tx_RdBuff pulses", i), rdCnt, vecs[i].expRd);
      check($sformatf("v%0d Tx_Done pulses", i), doneCnt, 1);
      check($sformatf("v%0d Tx_AbortedTrans pulses", i), abCnt, 0);
      if (vecs[i].fcsEn)
        check($sformatf("v%0d FCS vs CRC model", i), fcsFromLine(got, vecs[i].fieldLen),
              crcModel(vecs[i].bytes, vecs[i].size));
    end

    // Tx_Start while busy must not restart or resize the frame.
    for (int b = 0; b < 4; b++) bufMem[b] = vecs[2].bytes[b];
    runFrame(vecs[2].size, 1'b0, -1, 3);
    check("busy start line bits", got, wrapFlags(vecs[2].field, vecs[2].fieldLen));
    check("busy start Tx_RdBuff pulses", rdCnt, 2);
    check("busy start Tx_Done pulses", doneCnt, 1);

    // Abort during the third payload byte (0x55 bytes, no insertion).
    for (int b = 0; b < 16; b++) bufMem[b] = 8'h55;
    runFrame(10, 1'b0, 26, -1);
    expLine = '0;
    ab = 8'hFE;
    for (int j = 0; j < 8; j++) expLine[j] = (j != 0) && (j != 7);
    for (int j = 0; j < 19; j++) expLine[8 + j] = (j % 2 == 0);
    for (int j = 0; j < 8; j++) expLine[27 + j] = ab[j];
    check("abort finished", timedOut, 1'b0);
    check("abort line bits", got, expLine);
    check("abort TxEN cycles", nGot, 35);
    check("abort Tx_RdBuff pulses", rdCnt, 4);
    check("abort Tx_AbortedTrans pulses", abCnt, 1);
    check("abort Tx_Done pulses", doneCnt, 0);

    probeIdle("reject size 0", 1'b1, 8'd0, 1'b0);
    probeIdle("reject size 127", 1'b1, 8'd127, 1'b0);
    probeIdle("abort in idle", 1'b0, 8'd4, 1'b1);

    // Reset in the middle of the data field.
    @(posedge Clk); #1;
    Tx_Start = 1'b1; Tx_FrameSize = 8'd4; Tx_FCSen = 1'b0;
    @(posedge Clk); #1;
    Tx_Start = 1'b0;
    repeat (12) @(posedge Clk);
    @(negedge Clk);
    check("pre-reset busy in data", {TxEN, Tx_Busy}, 2'b11);
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    check("mid-frame reset outputs", {Tx, TxEN, Tx_Busy, Tx_Done, Tx_AbortedTrans}, 5'b10000);
    probeIdle("after reset quiet", 1'b0, 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
